// File: rtl/seq_ripple_subtractor.sv
// Chunked multi-cycle ripple-borrow subtractor: diff = a - b - bin, Chunk bits per clock,
// with valid/ready handshakes on both the operand and the result side.
module seq_ripple_subtractor #(
  parameter int MaxSize = 128,
  parameter int Chunk   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MaxSize-1:0] a,
  input  logic [MaxSize-1:0] b,
  input  logic               bin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MaxSize-1:0] diff,
  output logic               bout,
  output logic               ovf
);

  localparam int N    = MaxSize / Chunk;
  localparam int CntW = (N > 1) ? $clog2(N) : 1;

  generate
    if (Chunk < 1 || (MaxSize % Chunk) != 0) begin : g_bad_chunk
      $error("seq_ripple_subtractor: MaxSize must be a positive multiple of Chunk");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [MaxSize-1:0] a_reg;
  logic [MaxSize-1:0] b_reg;
  logic               borrow_reg;
  logic [CntW-1:0]    cnt;
  logic [Chunk-1:0]   a_chunk;
  logic [Chunk-1:0]   b_chunk;
  logic [Chunk:0]     chunk_res;
  logic               last_chunk;

  // One extra bit on the chunk subtract so its MSB is the borrow into the next chunk
  always_comb begin
    a_chunk    = a_reg[cnt*Chunk +: Chunk];
    b_chunk    = b_reg[cnt*Chunk +: Chunk];
    chunk_res  = {1'b0, a_chunk} - {1'b0, b_chunk} - {{Chunk{1'b0}}, borrow_reg};
    last_chunk = (cnt == CntW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_chunk) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers are overwritten chunk by chunk and otherwise hold the last result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      bout       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= bin;
            cnt        <= '0;
          end
        end
        RUN: begin
          diff[cnt*Chunk +: Chunk] <= chunk_res[Chunk-1:0];
          borrow_reg               <= chunk_res[Chunk];
          cnt                      <= cnt + CntW'(1);
          if (last_chunk) begin
            bout <= chunk_res[Chunk];
            ovf  <= (a_reg[MaxSize-1] != b_reg[MaxSize-1]) &&
                    (chunk_res[Chunk-1] != a_reg[MaxSize-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
